// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - State encoding, grant ids and tie-break helper for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_ACC = 2'd1,
        D_ACC = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

    // A tie goes to whichever port did not win the previous grant.
    function automatic logic pick_grant(input logic if_pend, input logic d_pend, input logic last_grant);
        if (if_pend && d_pend) begin
            return ~last_grant;
        end
        return d_pend ? GNT_D : GNT_IF;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - Core-side fetch/data ports and memory-side bus of the arbiter
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;

    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_valid;

    logic          err;
    logic          stall;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    // master: the arbiter, which serves the core and drives the memory
    modport master (
        input  if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_valid, d_rdata, d_valid, err, stall,
               mem_addr, mem_wdata, mem_read, mem_write
    );

    // slave: the surrounding core and memory model
    modport slave (
        output if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_valid, d_rdata, d_valid, err, stall,
               mem_addr, mem_wdata, mem_read, mem_write
    );

endinterface

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// rtl/mem_port_arbiter_timeout_ctr.sv - Access watchdog; expire flags the last permitted wait cycle
module arb_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

            logic [CW-1:0] r_count;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_count <= '0;
                end else if (clear) begin
                    r_count <= '0;
                end else if (enable) begin
                    r_count <= r_count + 1'b1;
                end
            end

            assign expire = enable && (r_count == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - Round-robin fetch/load-store arbiter for a shared variable-latency memory
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.master bus
);

    arb_state_t    r_state;
    logic          r_last_grant;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_mem_read;
    logic          r_mem_write;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_d_rdata;
    logic          r_if_valid;
    logic          r_d_valid;
    logic          r_err;

    arb_state_t    w_state_nxt;
    logic          w_last_grant_nxt;
    logic [AW-1:0] w_mem_addr_nxt;
    logic [DW-1:0] w_mem_wdata_nxt;
    logic          w_mem_read_nxt;
    logic          w_mem_write_nxt;
    logic [DW-1:0] w_if_rdata_nxt;
    logic [DW-1:0] w_d_rdata_nxt;
    logic          w_if_valid_nxt;
    logic          w_d_valid_nxt;
    logic          w_err_nxt;

    logic          w_if_pend;
    logic          w_d_pend;
    logic          w_in_acc;
    logic          w_expire;
    logic          w_gnt;

    assign w_if_pend = bus.if_req;
    assign w_d_pend  = bus.d_read | bus.d_write;
    assign w_in_acc  = (r_state == I_ACC) || (r_state == D_ACC);

    arb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (!w_in_acc),
        .enable (w_in_acc && !bus.mem_ready),
        .expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_last_grant <= GNT_IF;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
            r_if_valid   <= 1'b0;
            r_d_valid    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_mem_read   <= w_mem_read_nxt;
            r_mem_write  <= w_mem_write_nxt;
            r_if_rdata   <= w_if_rdata_nxt;
            r_d_rdata    <= w_d_rdata_nxt;
            r_if_valid   <= w_if_valid_nxt;
            r_d_valid    <= w_d_valid_nxt;
            r_err        <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_mem_read_nxt   = r_mem_read;
        w_mem_write_nxt  = r_mem_write;
        w_if_rdata_nxt   = r_if_rdata;
        w_d_rdata_nxt    = r_d_rdata;
        w_if_valid_nxt   = r_if_valid;
        w_d_valid_nxt    = r_d_valid;
        w_err_nxt        = r_err;
        w_gnt            = GNT_IF;

        case (r_state)
            IDLE: begin
                if (w_if_pend || w_d_pend) begin
                    w_gnt            = pick_grant(w_if_pend, w_d_pend, r_last_grant);
                    w_last_grant_nxt = w_gnt;
                    if (w_gnt == GNT_D) begin
                        w_state_nxt    = D_ACC;
                        w_mem_addr_nxt = bus.d_addr;
                        // A simultaneous read+write is served as a store only.
                        if (bus.d_write) begin
                            w_mem_write_nxt = 1'b1;
                            w_mem_wdata_nxt = bus.d_wdata;
                        end else begin
                            w_mem_read_nxt  = 1'b1;
                        end
                    end else begin
                        w_state_nxt    = I_ACC;
                        w_mem_addr_nxt = bus.if_addr;
                        w_mem_read_nxt = 1'b1;
                    end
                end
            end
            I_ACC, D_ACC: begin
                // mem_ready outranks an abort landing on the same cycle.
                if (bus.mem_ready || w_expire) begin
                    w_state_nxt     = DONE;
                    w_mem_read_nxt  = 1'b0;
                    w_mem_write_nxt = 1'b0;
                    w_err_nxt       = !bus.mem_ready;
                    if (r_state == I_ACC) begin
                        w_if_valid_nxt = 1'b1;
                        if (bus.mem_ready) begin
                            w_if_rdata_nxt = bus.mem_rdata;
                        end
                    end else begin
                        w_d_valid_nxt = 1'b1;
                        if (bus.mem_ready && !r_mem_write) begin
                            w_d_rdata_nxt = bus.mem_rdata;
                        end
                    end
                end
            end
            DONE: begin
                w_state_nxt    = IDLE;
                w_if_valid_nxt = 1'b0;
                w_d_valid_nxt  = 1'b0;
                w_err_nxt      = 1'b0;
            end
        endcase
    end

    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_read  = r_mem_read;
    assign bus.mem_write = r_mem_write;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.if_valid  = r_if_valid;
    assign bus.d_valid   = r_d_valid;
    assign bus.err       = r_err;
    assign bus.stall     = (w_if_pend & ~r_if_valid) | (w_d_pend & ~r_d_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - Directed and randomized checks of mem_port_arbiter against a transaction model
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) mif();

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    // Transaction model: an access is either absent, in flight (counting its wait
    // cycles), or in its single completion-pulse cycle.
    bit        m_busy, m_pulse, m_port, m_wr, m_last;
    int        m_cyc;
    bit        want_i, want_d;
    bit [31:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_d_rdata;
    bit        e_mem_read, e_mem_write, e_if_valid, e_d_valid, e_err;

    task close_access(input bit timed_out);
        m_busy      = 1'b0;
        m_pulse     = 1'b1;
        e_mem_read  = 1'b0;
        e_mem_write = 1'b0;
        e_err       = timed_out;
        if (m_port) e_d_valid = 1'b1;
        else        e_if_valid = 1'b1;
        if (!timed_out && !m_wr) begin
            if (m_port) e_d_rdata = mif.mem_rdata;
            else        e_if_rdata = mif.mem_rdata;
        end
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            m_busy = 0; m_pulse = 0; m_last = 0; m_cyc = 0; m_port = 0; m_wr = 0;
            e_mem_addr = 0; e_mem_wdata = 0; e_if_rdata = 0; e_d_rdata = 0;
            e_mem_read = 0; e_mem_write = 0; e_if_valid = 0; e_d_valid = 0; e_err = 0;
        end else if (m_pulse) begin
            m_pulse = 0; e_if_valid = 0; e_d_valid = 0; e_err = 0;
        end else if (m_busy) begin
            m_cyc = m_cyc + 1;
            if (mif.mem_ready)                close_access(1'b0);
            else if (TO > 0 && m_cyc == TO)   close_access(1'b1);
        end else begin
            want_i = mif.if_req;
            want_d = mif.d_read | mif.d_write;
            if (want_i || want_d) begin
                m_port     = (want_i && want_d) ? !m_last : want_d;
                m_last     = m_port;
                m_busy     = 1'b1;
                m_cyc      = 0;
                m_wr       = m_port && mif.d_write;
                e_mem_addr = m_port ? mif.d_addr : mif.if_addr;
                if (m_wr) begin
                    e_mem_write = 1'b1;
                    e_mem_wdata = mif.d_wdata;
                end else begin
                    e_mem_read = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("mem_addr",  mif.mem_addr,  e_mem_addr);
            chk("mem_wdata", mif.mem_wdata, e_mem_wdata);
            chk("mem_read",  32'(mif.mem_read),  32'(e_mem_read));
            chk("mem_write", 32'(mif.mem_write), 32'(e_mem_write));
            chk("if_rdata",  mif.if_rdata,  e_if_rdata);
            chk("d_rdata",   mif.d_rdata,   e_d_rdata);
            chk("if_valid",  32'(mif.if_valid), 32'(e_if_valid));
            chk("d_valid",   32'(mif.d_valid),  32'(e_d_valid));
            chk("err",       32'(mif.err),      32'(e_err));
            chk("stall",     32'(mif.stall),
                32'((mif.if_req & ~e_if_valid) | ((mif.d_read | mif.d_write) & ~e_d_valid)));
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #2;
    endtask

    int n_a, n_b, n_c, n_d;
    bit seen, found;
    logic [31:0] grants [4];
    int n_g;
    bit prev_rd;
    int kind;

    initial begin
        mif.if_req = 0; mif.if_addr = 0; mif.d_read = 0; mif.d_write = 0;
        mif.d_addr = 0; mif.d_wdata = 0; mif.mem_rdata = 0; mif.mem_ready = 0;
        reset = 0;
        drive_edge();
        drive_edge();
        reset = 1;
        cmp_en = 1;

        @(negedge clk);
        chk("rst_mem_read", 32'(mif.mem_read), 0);
        chk("rst_mem_addr", mif.mem_addr, 0);
        chk("rst_if_valid", 32'(mif.if_valid), 0);
        chk("rst_d_rdata",  mif.d_rdata, 0);
        chk("rst_stall",    32'(mif.stall), 0);
        drive_edge();

        // Lone fetch with a zero-wait memory
        mif.if_req = 1; mif.if_addr = 32'h0000_0040;
        mif.mem_ready = 1; mif.mem_rdata = 32'h2008_0005;
        n_a = 0; n_b = 0; n_c = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mif.mem_read) begin n_a++; chk("fetch_addr", mif.mem_addr, 32'h40); end
            if (mif.if_valid) begin n_b++; chk("fetch_rdata", mif.if_rdata, 32'h2008_0005); end
            if (mif.stall) n_c++;
            drive_edge();
            if (mif.if_valid) mif.if_req = 0;
        end
        chk("fetch_rd_cycles", n_a, 1);
        chk("fetch_valid_pulses", n_b, 1);
        chk("fetch_stall_cycles", n_c, 2);

        // Store with two wait states
        mif.d_write = 1; mif.d_addr = 32'h100; mif.d_wdata = 32'hCAFE_F00D;
        mif.mem_ready = 0; mif.mem_rdata = 32'hDEAD_BEEF;
        n_a = 0; n_b = 0; n_c = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (mif.mem_write) begin
                n_a++;
                chk("store_addr", mif.mem_addr, 32'h100);
                chk("store_wdata", mif.mem_wdata, 32'hCAFE_F00D);
            end
            if (mif.mem_read) n_c++;
            if (mif.d_valid) begin
                n_b++;
                chk("store_err", 32'(mif.err), 0);
                chk("store_d_rdata", mif.d_rdata, 0);
            end
            drive_edge();
            if (mif.d_valid) mif.d_write = 0;
            mif.mem_ready = mif.mem_write && (n_a == 2);
        end
        chk("store_wr_cycles", n_a, 3);
        chk("store_valid_pulses", n_b, 1);
        chk("store_no_read", n_c, 0);

        // Load that times out, then a normal fetch
        mif.d_read = 1; mif.d_addr = 32'h200; mif.mem_ready = 0;
        n_a = 0; n_b = 0; n_c = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (mif.mem_read && mif.mem_addr == 32'h200) n_a++;
            if (mif.d_valid) begin
                n_b++;
                chk("timeout_err", 32'(mif.err), 1);
                chk("timeout_d_rdata", mif.d_rdata, 0);
            end
            if (mif.if_valid) begin
                n_c++;
                chk("after_to_err", 32'(mif.err), 0);
                chk("after_to_rdata", mif.if_rdata, 32'h1234_5678);
            end
            drive_edge();
            if (mif.d_valid) begin
                mif.d_read = 0; mif.if_req = 1; mif.if_addr = 32'h44;
                mif.mem_ready = 1; mif.mem_rdata = 32'h1234_5678;
            end
            if (mif.if_valid) mif.if_req = 0;
        end
        chk("timeout_rd_cycles", n_a, 4);
        chk("timeout_pulses", n_b, 1);
        chk("after_to_fetch", n_c, 1);

        // mem_ready arriving on the last permitted cycle
        mif.d_read = 1; mif.d_addr = 32'h300; mif.mem_ready = 0; mif.mem_rdata = 32'h0BAD_CAFE;
        n_a = 0; n_b = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mif.mem_read) n_a++;
            if (mif.d_valid) begin
                n_b++;
                chk("edge_err", 32'(mif.err), 0);
                chk("edge_d_rdata", mif.d_rdata, 32'h0BAD_CAFE);
            end
            drive_edge();
            if (mif.d_valid) mif.d_read = 0;
            mif.mem_ready = mif.mem_read && (n_a == 3);
        end
        chk("edge_rd_cycles", n_a, 4);
        chk("edge_pulses", n_b, 1);

        // Read and write together act as a store
        mif.d_read = 1; mif.d_write = 1; mif.d_addr = 32'h304; mif.d_wdata = 32'h5555_AAAA;
        mif.mem_ready = 1;
        n_a = 0; n_c = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (mif.mem_write) n_a++;
            if (mif.mem_read) n_c++;
            drive_edge();
            if (mif.d_valid) begin mif.d_read = 0; mif.d_write = 0; end
        end
        chk("both_wr_cycles", n_a, 1);
        chk("both_no_read", n_c, 0);

        // Tie fairness from reset
        reset = 0;
        mif.if_req = 1; mif.if_addr = 32'h1000; mif.d_read = 1; mif.d_addr = 32'h2000;
        mif.mem_ready = 1;
        drive_edge();
        reset = 1;
        n_g = 0; prev_rd = 0;
        for (int k = 0; k < 4; k++) grants[k] = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (mif.mem_read && !prev_rd && n_g < 4) begin grants[n_g] = mif.mem_addr; n_g++; end
            prev_rd = mif.mem_read;
            drive_edge();
        end
        chk("grant0", grants[0], 32'h2000);
        chk("grant1", grants[1], 32'h1000);
        chk("grant2", grants[2], 32'h2000);
        chk("grant3", grants[3], 32'h1000);
        mif.if_req = 0; mif.d_read = 0;
        for (int k = 0; k < 4; k++) drive_edge();

        // Reset in the middle of a fetch
        mif.if_req = 1; mif.if_addr = 32'h80; mif.mem_ready = 0; mif.mem_rdata = 32'h7777_0001;
        found = 0;
        for (int k = 0; k < 6 && !found; k++) begin
            @(negedge clk);
            if (mif.mem_read) found = 1;
            drive_edge();
        end
        chk("rst_mid_reached_acc", 32'(found), 1);
        reset = 0;
        drive_edge();
        reset = 1; mif.mem_ready = 1;
        @(negedge clk);
        chk("rst_mid_mem_read", 32'(mif.mem_read), 0);
        chk("rst_mid_if_valid", 32'(mif.if_valid), 0);
        chk("rst_mid_mem_addr", mif.mem_addr, 0);
        n_b = 0;
        for (int k = 0; k < 6; k++) begin
            drive_edge();
            if (mif.if_valid) mif.if_req = 0;
            @(negedge clk);
            if (mif.if_valid) begin
                n_b++;
                chk("rst_mid_reserve_rdata", mif.if_rdata, 32'h7777_0001);
            end
        end
        chk("rst_mid_reserved", n_b, 1);
        drive_edge();

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) != 0);
            mif.mem_ready = ($urandom_range(0, 9) < 4);
            mif.mem_rdata = $urandom;
            if (mif.if_req) begin
                if (mif.if_valid) begin
                    if ($urandom_range(0, 2) == 0) mif.if_addr = $urandom;
                    else mif.if_req = 0;
                end
            end else if ($urandom_range(0, 1) == 1) begin
                mif.if_req = 1; mif.if_addr = $urandom;
            end
            if (mif.d_read || mif.d_write) begin
                if (mif.d_valid) begin
                    mif.d_read = 0; mif.d_write = 0;
                end
            end else if ($urandom_range(0, 1) == 1) begin
                kind = $urandom_range(0, 9);
                mif.d_read  = (kind < 5) || (kind == 9);
                mif.d_write = (kind >= 5);
                mif.d_addr  = $urandom;
                mif.d_wdata = $urandom;
            end
            drive_edge();
        end

        reset = 1;
        mif.if_req = 0; mif.d_read = 0; mif.d_write = 0; mif.mem_ready = 1;
        for (int k = 0; k < 8; k++) drive_edge();
        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the core's instruction-fetch port and its load/store port.
- Sits between the MIPS datapath (inst_addr/instr, data_addr/data_in/data_out, mem_read/mem_write) and the unified memory model.
- Sequences each access with a request/valid handshake, arbitrates ties round-robin and aborts accesses that exceed a timeout.
- Drives a stall to the core while any request is outstanding.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, maximum cycles in an access state before abort; 0 disables the timeout

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-low reset
- if_req  in  1  instruction fetch request; held until if_valid
- if_addr  in  AW  fetch address (the PC); stable while if_req
- if_rdata  out  DW  fetched instruction; valid with if_valid
- if_valid  out  1  one-cycle completion pulse for fetch
- d_read  in  1  load request; held until d_valid
- d_write  in  1  store request; held until d_valid
- d_addr  in  AW  load/store address (ALU result)
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data; valid with d_valid
- d_valid  out  1  one-cycle completion pulse for data
- err  out  1  high with the valid pulse when the access timed out
- stall  out  1  (if_req & ~if_valid) | ((d_read|d_write) & ~d_valid), combinational
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_rdata  in  DW  memory read data; sampled when mem_ready
- mem_ready  in  1  memory completion; may be high in the first strobe cycle

Behaviour:
- Reset (reset=0 at an edge): state=IDLE, last_grant=IF. All registered outputs are 0: if_rdata, d_rdata, if_valid, d_valid, err, mem_*, and the timeout counter.
- Reset mid-access: the strobes drop at that edge, no valid pulse is issued and the access is discarded.
- States: IDLE, I_ACC, D_ACC, DONE.
- IDLE transitions:
  - Only if_req pending -> I_ACC.
  - Only data pending -> D_ACC.
  - Both pending -> grant the port not in last_grant. After reset last_grant=IF, so data wins the first tie.
  - Update last_grant on every grant.
- Entering I_ACC: mem_addr<=if_addr, mem_read<=1.
- Entering D_ACC:
  - mem_addr<=d_addr.
  - If d_write: mem_write<=1 and mem_wdata<=d_wdata.
  - Else: mem_read<=1.
  - d_read and d_write both high is treated as a write only.
- Address, data and strobes are held constant through the whole ACC state.
- ACC with mem_ready=1 -> DONE:
  - Strobes cleared.
  - Read data: mem_rdata is latched into if_rdata or d_rdata. A write leaves d_rdata unchanged.
  - The matching valid is set to 1 and err to 0.
- Timeout (TIMEOUT>0):
  - The counter clears on ACC entry and increments each ACC cycle with mem_ready=0.
  - At count TIMEOUT-1 with mem_ready=0 -> DONE. Strobes are cleared, the matching valid=1 and err=1; the rdata register is unchanged.
  - mem_ready arriving in the same cycle as the abort condition wins: normal completion, err=0.
- DONE: exactly one cycle. Valid/err are high; the requester must drop or replace its request by the next edge. DONE -> IDLE with valid and err cleared.
- Latency:
  - Request seen in IDLE at edge N: strobes high from N+1.
  - mem_ready high in the cycle ending at edge M: valid high for the cycle M to M+1.
  - Minimum access is 3 cycles (IDLE, ACC, DONE).
- Request deasserted during ACC: the access still completes and the valid pulse is still issued. The requester ignores it.
- stall never depends on memory signals combinationally, so there is no loop through the core.

Decomposition:
- Shared package holds the state encoding constants (IDLE=2'd0, I_ACC=2'd1, D_ACC=2'd2, DONE=2'd3) and the grant id constants (GNT_IF=1'b0, GNT_D=1'b1).
- One natural sub-module: arb_timeout_ctr. It takes clk, reset, clear, enable and outputs expire, parameterised by TIMEOUT, with expire forced to 0 when TIMEOUT=0.

Test Plan:
- Lone fetch: if_addr=32'h0000_0040, mem_ready tied 1, mem_rdata=32'h2008_0005 -> mem_read high 1 cycle at addr 0x40; if_valid pulses 1 cycle later with if_rdata=32'h2008_0005; stall high 2 cycles.
- Store with wait states: d_write, d_addr=32'h100, d_wdata=32'hCAFE_F00D, mem_ready after 3 cycles -> mem_write held 3 cycles with stable addr/data; d_valid 1 pulse; err=0; d_rdata unchanged.
- Tie and fairness: if_req and d_read held continuously from reset -> grant order D, IF, D, IF; no two consecutive grants to the same port.
- Timeout: TIMEOUT=4, d_read, mem_ready=0 -> mem_read high exactly 4 cycles, then d_valid=1 and err=1; next fetch proceeds normally with err=0.
- Boundary: TIMEOUT=4 with mem_ready first high in the 4th ACC cycle -> normal completion, err=0, data latched. Separately, d_read and d_write both high -> write only, mem_read stays 0.
- Reset mid-access: reset=0 for one edge during I_ACC -> next cycle all outputs 0, state IDLE, no if_valid; the request is re-served after reset releases.
